// File: rtl/uart_tx_prescaled.sv
// Single-clock UART transmitter with a prescaled bit period.
// A one-deep holding register lets frames run back to back.
module uart_tx_prescaled #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  output logic                  ready,
  input  logic [5:0]            Prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [5:0]            r_cnt;
  logic [5:0]            r_last;
  logic [BW-1:0]         r_bit;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_tx;
  logic                  r_busy;

  logic w_accept;
  logic w_last;
  logic w_load;

  assign w_accept = Data_Valid && !r_hold_full;
  assign w_last   = (r_cnt == r_last);
  assign w_load   = r_hold_full &&
                    ((r_state == S_IDLE) ||
                     ((r_state == S_STOP) && w_last));

  assign ready  = !r_hold_full;
  assign TX_OUT = r_tx;
  assign busy   = r_busy;

  // A reload frees the holding register unless a new word lands on the same edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_load)
        r_hold_full <= 1'b0;
      if (w_accept) begin
        r_hold      <= P_DATA;
        r_hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_last    <= '0;
      r_bit     <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else if (w_load) begin
      r_state   <= S_START;
      r_shift   <= r_hold;
      r_cnt     <= '0;
      r_last    <= (Prescale == 6'd0) ? 6'd0 : Prescale - 6'd1;
      r_bit     <= '0;
      r_par_en  <= parity_enable;
      r_par_bit <= (^r_hold) ^ parity_type;
      r_tx      <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
        end
        S_START: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_DATA: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_bit == LAST_BIT) begin
              if (r_par_en) begin
                r_state <= S_PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + BW'(1);
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_PARITY: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_STOP: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_prescaled.sv
// Directed bench for uart_tx_prescaled.
// Frames are compared clock by clock against hand-built bit vectors.
module tb_uart_tx_prescaled;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       ready;
  logic [5:0] Prescale;
  logic       parity_enable;
  logic       parity_type;
  logic       TX_OUT;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_prescaled #(.DATA_WIDTH(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .ready        (ready),
    .Prescale     (Prescale),
    .parity_enable(parity_enable),
    .parity_type  (parity_type),
    .TX_OUT       (TX_OUT),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  // Returns at the falling edge after the accepting rising edge
  task automatic send_word(input logic [7:0] d);
    @(negedge CLK);
    P_DATA     = d;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    n_chk++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL send_ready_drop: ready=%b expected 0", ready);
    end
  endtask

  // Called at the falling edge inside the first START clock
  task automatic check_frame(input logic [7:0] d, input int p,
                             input bit pen, input bit pb,
                             input string nm);
    logic [10:0] bits;
    int          nb;
    logic        bad;
    logic        atx;
    logic        abusy;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (pen) bits[9] = pb;
    nb = pen ? 11 : 10;
    for (int b = 0; b < nb; b++) begin
      bad   = 1'b0;
      atx   = 1'b0;
      abusy = 1'b0;
      for (int k = 0; k < p; k++) begin
        if (!bad && (TX_OUT !== bits[b] || busy !== 1'b1)) begin
          bad   = 1'b1;
          atx   = TX_OUT;
          abusy = busy;
        end
        @(negedge CLK);
      end
      n_chk++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s bit %0d: TX_OUT=%b busy=%b, expected TX_OUT=%b busy=1",
                 nm, b, atx, abusy, bits[b]);
      end
    end
  endtask

  task automatic check_idle(input string nm);
    n_chk++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle: TX_OUT=%b busy=%b ready=%b, expected 1 0 1",
               nm, TX_OUT, busy, ready);
    end
  endtask

  task automatic check_latency(input string nm);
    n_chk++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s latency: TX_OUT=%b busy=%b, expected 1 0",
               nm, TX_OUT, busy);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST           = 1'b0;
    Data_Valid    = 1'b0;
    P_DATA        = 8'h00;
    Prescale      = 6'd8;
    parity_enable = 1'b0;
    parity_type   = 1'b0;
    #12;
    check_idle("reset");
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_idle("post_reset");
  endtask

  task automatic test_basic();
    Prescale      = 6'd8;
    parity_enable = 1'b0;
    send_word(8'hA5);
    check_latency("basic");
    check_frame(8'hA5, 8, 1'b0, 1'b0, "basic_a5");
    check_idle("basic_end");
  endtask

  task automatic test_parity();
    Prescale      = 6'd8;
    parity_enable = 1'b1;
    parity_type   = 1'b0;
    send_word(8'hA5);
    check_latency("even");
    check_frame(8'hA5, 8, 1'b1, 1'b0, "even_a5");
    check_idle("even_end");
    parity_type = 1'b1;
    send_word(8'hA5);
    check_latency("odd");
    check_frame(8'hA5, 8, 1'b1, 1'b1, "odd_a5");
    check_idle("odd_end");
    parity_enable = 1'b0;
    parity_type   = 1'b0;
  endtask

  task automatic test_back_to_back();
    Prescale = 6'd8;
    send_word(8'h00);
    @(negedge CLK);
    fork
      check_frame(8'h00, 8, 1'b0, 1'b0, "b2b_first");
      begin
        repeat (20) @(negedge CLK);
        send_word(8'hFF);
        repeat (10) @(negedge CLK);
        n_chk++;
        if (ready !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_ready_hold: ready=%b expected 0", ready);
        end
      end
    join
    n_chk++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_reload: ready=%b expected 1", ready);
    end
    check_frame(8'hFF, 8, 1'b0, 1'b0, "b2b_second");
    check_idle("b2b_end");
  endtask

  task automatic test_prescale();
    Prescale = 6'd0;
    send_word(8'h3C);
    @(negedge CLK);
    check_frame(8'h3C, 1, 1'b0, 1'b0, "pre0");
    check_idle("pre0_end");
    Prescale = 6'd1;
    send_word(8'h3C);
    @(negedge CLK);
    check_frame(8'h3C, 1, 1'b0, 1'b0, "pre1");
    check_idle("pre1_end");
    Prescale = 6'd63;
    send_word(8'h3C);
    @(negedge CLK);
    check_frame(8'h3C, 63, 1'b0, 1'b0, "pre63");
    check_idle("pre63_end");
  endtask

  task automatic test_reset_mid();
    Prescale = 6'd8;
    send_word(8'h00);
    @(negedge CLK);
    repeat (8 + 3 * 8 + 4) @(negedge CLK);
    n_chk++;
    if (TX_OUT !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: TX_OUT=%b busy=%b, expected 0 1",
               TX_OUT, busy);
    end
    #2;
    RST = 1'b0;
    #1;
    check_idle("rst_mid_async");
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_idle("rst_mid_release");
    send_word(8'h5A);
    @(negedge CLK);
    check_frame(8'h5A, 8, 1'b0, 1'b0, "rst_mid_5a");
    check_idle("rst_mid_end");
  endtask

  task automatic test_config_change();
    Prescale      = 6'd4;
    parity_enable = 1'b1;
    parity_type   = 1'b1;
    send_word(8'hC3);
    @(negedge CLK);
    fork
      check_frame(8'hC3, 4, 1'b1, 1'b1, "cfg_old");
      begin
        repeat (5) @(negedge CLK);
        Prescale    = 6'd2;
        parity_type = 1'b0;
        send_word(8'h5A);
      end
    join
    check_frame(8'h5A, 2, 1'b1, 1'b0, "cfg_new");
    check_idle("cfg_end");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_prescale();
    test_reset_mid();
    test_config_change();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
